// File: rtl/cbm2_bank_ctrl_if.sv
// Bus bundle between the 6509 core / bus decoder and the CBM-II bank register block.
// The master side is the CPU core plus decoder; the slave side is cbm2_bank_ctrl.
interface cbm2_bank_ctrl_if;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_sync;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_po;
  logic        reg_hit;
  logic [7:0]  reg_data;
  logic [3:0]  exec_bank;
  logic [3:0]  ind_bank;

  modport master (
    output cpu_en, cpu_addr, cpu_do, cpu_we, cpu_sync, cpu_din,
    input  cpu_po, reg_hit, reg_data, exec_bank, ind_bank
  );

  modport slave (
    input  cpu_en, cpu_addr, cpu_do, cpu_we, cpu_sync, cpu_din,
    output cpu_po, reg_hit, reg_data, exec_bank, ind_bank
  );
endinterface

// File: rtl/cbm2_bank_ctrl.sv
// 6509 bank registers ($0000 execution, $0001 indirection) and (zp),Y indirection tracking.
// Optional macro CBM2_BANK_RDBACK_EN enables register readback over RAM at $0000/$0001.
module cbm2_bank_ctrl #(
  parameter logic [3:0] RESET_BANK = 4'hF
) (
  input logic              clk_sys,
  input logic              reset_n,
  cbm2_bank_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    EXEC  = 2'd0,
    TRACK = 2'd1,
    IND   = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_s;
  logic [3:0] exec_r;
  logic [3:0] ind_r;
  logic       use_ind_s;

  // Only LDA (zp),Y and STA (zp),Y reach their data through the indirection bank.
  function automatic logic is_ind_op(input logic [7:0] op);
    return (op == 8'hB1) || (op == 8'h91);
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c == 3'h7) ? c : (c + 3'd1);
  endfunction

  // Bank register writes; decoded in every bank, bus cycle is not blocked.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exec_r <= RESET_BANK;
      ind_r  <= RESET_BANK;
    end else if (bus.cpu_en && bus.cpu_we) begin
      if (bus.cpu_addr == 16'h0000) begin
        exec_r <= bus.cpu_do[3:0];
      end else if (bus.cpu_addr == 16'h0001) begin
        ind_r <= bus.cpu_do[3:0];
      end
    end
  end

  // FSM state and cycle counter registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= EXEC;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: an opcode fetch always re-evaluates, whatever state we are in.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (bus.cpu_en) begin
      if (bus.cpu_sync) begin
        if (is_ind_op(bus.cpu_din)) begin
          state_s = TRACK;
          cnt_s   = 3'd1;
        end else begin
          state_s = EXEC;
          cnt_s   = 3'd0;
        end
      end else begin
        case (state_r)
          EXEC: begin
            state_s = EXEC;
            cnt_s   = 3'd0;
          end
          TRACK: begin
            cnt_s = sat_inc(cnt_r);
            if (cnt_r >= 3'd3) begin
              state_s = IND;
            end else begin
              state_s = TRACK;
            end
          end
          IND: begin
            state_s = IND;
            cnt_s   = sat_inc(cnt_r);
          end
          default: begin
            state_s = EXEC;
            cnt_s   = 3'd0;
          end
        endcase
      end
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // Opcode fetches are always in the execution bank, even while still in IND.
  assign use_ind_s     = (state_r == IND) && !bus.cpu_sync;
  assign bus.cpu_po    = {4'b0000, (use_ind_s ? ind_r : exec_r)};
  assign bus.exec_bank = exec_r;
  assign bus.ind_bank  = ind_r;

`ifdef CBM2_BANK_RDBACK_EN
  assign bus.reg_hit  = (bus.cpu_addr[15:1] == 15'd0) && !bus.cpu_we;
  assign bus.reg_data = {4'b0000, (bus.cpu_addr[0] ? ind_r : exec_r)};
`else
  assign bus.reg_hit  = 1'b0;
  assign bus.reg_data = 8'h00;
`endif

  wire unused_do_hi = &{1'b0, bus.cpu_do[7:4]};

endmodule

// File: tb/tb_cbm2_bank_ctrl.sv
// Scoreboard bench for cbm2_bank_ctrl: directed CPU cycles push expectations, a monitor checks each cpu_en cycle.
module tb_cbm2_bank_ctrl;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  cbm2_bank_ctrl_if bus ();

  cbm2_bank_ctrl #(.RESET_BANK(4'hF)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

`ifdef CBM2_BANK_RDBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] po;
    logic       hit;
    logic [7:0] rd;
    logic [3:0] ex;
    logic [3:0] ind;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // One CPU bus cycle; expected values are the pre-edge bank registers and bank output.
  task automatic vec(input string name, input logic [15:0] addr, input logic [7:0] dout,
                     input logic we, input logic sync, input logic [7:0] din,
                     input logic [7:0] exp_po, input logic [3:0] exp_ex,
                     input logic [3:0] exp_ind, input logic rst_low);
    exp_t e;
    @(posedge clk_sys);
    #1;
    e.name = name;
    e.po   = exp_po;
    e.ex   = exp_ex;
    e.ind  = exp_ind;
    e.hit  = RB && (addr[15:1] == 15'd0) && !we;
    e.rd   = RB ? {4'h0, (addr[0] ? exp_ind : exp_ex)} : 8'h00;
    exp_q.push_back(e);
    reset_n      = !rst_low;
    bus.cpu_addr = addr;
    bus.cpu_do   = dout;
    bus.cpu_we   = we;
    bus.cpu_sync = sync;
    bus.cpu_din  = din;
    bus.cpu_en   = 1'b1;
  endtask

  // Opcode fetch plus operand / ZP lo / ZP hi cycles, all expected in the execution bank.
  task automatic prefix(input string name, input logic [7:0] op, input logic [3:0] ex,
                        input logic [3:0] ind);
    vec({name, "_c0"}, 16'h1000, 8'h00, 1'b0, 1'b1, op,    {4'h0, ex}, ex, ind, 1'b0);
    vec({name, "_c1"}, 16'h1001, 8'h00, 1'b0, 1'b0, 8'h20, {4'h0, ex}, ex, ind, 1'b0);
    vec({name, "_c2"}, 16'h0020, 8'h00, 1'b0, 1'b0, 8'h00, {4'h0, ex}, ex, ind, 1'b0);
    vec({name, "_c3"}, 16'h0021, 8'h00, 1'b0, 1'b0, 8'h30, {4'h0, ex}, ex, ind, 1'b0);
  endtask

  // Monitor: every cpu_en cycle the DUT presents a bank decision to check.
  always @(negedge clk_sys) begin
    if (bus.cpu_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cycle: no expectation queued, cpu_po=%h", bus.cpu_po);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.cpu_po !== e.po || bus.reg_hit !== e.hit || bus.reg_data !== e.rd ||
            bus.exec_bank !== e.ex || bus.ind_bank !== e.ind) begin
          n_err++;
          $display("FAIL %s: got po=%h hit=%b rd=%h exec=%h ind=%h, want po=%h hit=%b rd=%h exec=%h ind=%h",
                   e.name, bus.cpu_po, bus.reg_hit, bus.reg_data, bus.exec_bank, bus.ind_bank,
                   e.po, e.hit, e.rd, e.ex, e.ind);
        end
      end
    end
  end

  initial begin
    bus.cpu_en   = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_do   = 8'h00;
    bus.cpu_we   = 1'b0;
    bus.cpu_sync = 1'b0;
    bus.cpu_din  = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // Reset state and register write latency
    vec("rst_idle",     16'h2000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'hF, 1'b0);
    vec("rst_read0",    16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'hF, 1'b0);
    vec("wr_exec",      16'h0000, 8'h01, 1'b1, 1'b0, 8'h00, 8'h0F, 4'hF, 4'hF, 1'b0);
    vec("wr_exec_eff",  16'h2000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'h1, 4'hF, 1'b0);
    vec("wr_ind",       16'h0001, 8'hF1, 1'b1, 1'b0, 8'h00, 8'h01, 4'h1, 4'hF, 1'b0);
    vec("wr_exec_back", 16'h0000, 8'h0F, 1'b1, 1'b0, 8'h00, 8'h01, 4'h1, 4'h1, 1'b0);

    // LDA (zp),Y without page cross
    prefix("b1", 8'hB1, 4'hF, 4'h1);
    vec("b1_c4",        16'h3005, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("b1_next_sync", 16'h1002, 8'h00, 1'b0, 1'b1, 8'hEA, 8'h0F, 4'hF, 4'h1, 1'b0);
    vec("nop_c1",       16'h1003, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'h1, 1'b0);

    // STA (zp),Y: dummy read and write both indirect
    prefix("s91", 8'h91, 4'hF, 4'h1);
    vec("s91_c4",       16'h3005, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("s91_c5",       16'h3005, 8'h55, 1'b1, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("s91_nsync",    16'h1002, 8'h00, 1'b0, 1'b1, 8'hEA, 8'h0F, 4'hF, 4'h1, 1'b0);

    // Back-to-back B1 (page cross) then 91 then B1 with reset in cycle 4
    prefix("bb1", 8'hB1, 4'hF, 4'h1);
    vec("bb1_c4",       16'h3005, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("bb1_c5_px",    16'h3105, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    prefix("bb2", 8'h91, 4'hF, 4'h1);
    vec("bb2_c4",       16'h3005, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("bb2_c5",       16'h3005, 8'hAA, 1'b1, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    prefix("bb3", 8'hB1, 4'hF, 4'h1);
    vec("bb3_c4_rst",   16'h3005, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'hF, 1'b1);
    vec("post_rst_wr",  16'h0001, 8'h01, 1'b1, 1'b0, 8'h00, 8'h0F, 4'hF, 4'hF, 1'b0);
    vec("post_rst_exec",16'h2000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'h1, 1'b0);

    // Unexpected sync while tracking aborts back to EXEC
    vec("abrt_c0",      16'h1000, 8'h00, 1'b0, 1'b1, 8'hB1, 8'h0F, 4'hF, 4'h1, 1'b0);
    vec("abrt_c1",      16'h1001, 8'h00, 1'b0, 1'b0, 8'h20, 8'h0F, 4'hF, 4'h1, 1'b0);
    vec("abrt_sync",    16'hFFFA, 8'h00, 1'b0, 1'b1, 8'hEA, 8'h0F, 4'hF, 4'h1, 1'b0);
    vec("abrt_c3",      16'h1003, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'h1, 1'b0);
    vec("abrt_c4",      16'h1004, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0F, 4'hF, 4'h1, 1'b0);

    // Writes to bank registers from inside IND cycles
    prefix("sim1", 8'h91, 4'hF, 4'h1);
    vec("sim1_c4",      16'h0001, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("sim1_wr_ind",  16'h0001, 8'h05, 1'b1, 1'b0, 8'h00, 8'h01, 4'hF, 4'h1, 1'b0);
    vec("sim1_nsync",   16'h1002, 8'h00, 1'b0, 1'b1, 8'hEA, 8'h0F, 4'hF, 4'h5, 1'b0);
    prefix("sim2", 8'h91, 4'hF, 4'h5);
    vec("sim2_c4",      16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05, 4'hF, 4'h5, 1'b0);
    vec("sim2_wr_exec", 16'h0000, 8'h02, 1'b1, 1'b0, 8'h00, 8'h05, 4'hF, 4'h5, 1'b0);
    vec("sim2_nsync",   16'h1002, 8'h00, 1'b0, 1'b1, 8'hEA, 8'h02, 4'h2, 4'h5, 1'b0);

    // Readback of $0001 / $0000 while executing in bank 2
    vec("rb_wr_ind",    16'h0001, 8'h03, 1'b1, 1'b0, 8'h00, 8'h02, 4'h2, 4'h5, 1'b0);
    vec("rb_rd1",       16'h0001, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 4'h2, 4'h3, 1'b0);
    vec("rb_rd0",       16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 4'h2, 4'h3, 1'b0);
    vec("rb_rd2",       16'h0002, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 4'h2, 4'h3, 1'b0);

    @(posedge clk_sys);
    #1 bus.cpu_en = 1'b0;
    repeat (3) @(posedge clk_sys);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cbm2_bank_ctrl.md
Name: cbm2_bank_ctrl

Overview:
- Models the 6509 on-chip bank registers: execution bank at $0000, indirection bank at $0001.
- Sits between the CPU core and the bus decoder. Drives the 8-bit bank number (cpu_po) that the decoder uses together with cpu_addr to pick RAM, ROM or I/O.
- Switches to the indirection bank for the data cycles of LDA (zp),Y ($B1) and STA (zp),Y ($91). All other cycles use the execution bank.

Parameters:
- RESET_BANK, 4'hF, value loaded into both bank registers at reset (system boots in bank 15).

Ports:
- clk_sys  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- cpu_en  input  1  CPU cycle strobe; one clk_sys pulse per completed 6509 bus cycle
- cpu_addr  input  16  CPU address of the current cycle
- cpu_do  input  8  CPU write data
- cpu_we  input  1  CPU write strobe of the current cycle
- cpu_sync  input  1  high during opcode fetch cycles
- cpu_din  input  8  data returned to the CPU in the current cycle (from the bus decoder)
- cpu_po  output  8  bank for the current cycle, zero-extended: {4'b0, bank}
- reg_hit  output  1  current cycle reads $0000 or $0001; the bus decoder data must be overridden
- reg_data  output  8  readback value {4'b0, register}
- exec_bank  output  4  current execution bank register, for debug/OSD
- ind_bank  output  4  current indirection bank register, for debug/OSD

Behaviour:
- Reset (async, reset_n=0):
  - exec and ind registers = RESET_BANK.
  - State = EXEC, cycle counter = 0.
  - cpu_po = {4'b0, RESET_BANK}; reg_hit = 0.
- All state changes happen only on clk_sys edges where cpu_en=1.
- Register writes:
  - cpu_en & cpu_we & cpu_addr==$0000 loads exec <= cpu_do[3:0].
  - cpu_en & cpu_we & cpu_addr==$0001 loads ind <= cpu_do[3:0].
  - Writes are decoded in every bank. The cycle is not blocked: cpu_we still passes to the bus decoder, so RAM underneath is also written.
  - The new value takes effect from the next CPU cycle. Zero additional latency beyond that.
- cpu_po is combinational from registered state: state==IND ? ind : exec.
- State machine:
  - EXEC: on cpu_en & cpu_sync, if cpu_din is $B1 or $91, go to TRACK with cnt=1. Otherwise stay in EXEC.
  - TRACK: on each cpu_en, cnt increments. Cycles 1 (operand), 2 (ZP lo) and 3 (ZP hi) use exec. On the cpu_en that ends cycle 3, go to IND.
  - IND: covers every cycle from cycle 4 until the next opcode fetch:
    - $B1: data read, plus the page-cross re-read.
    - $91: dummy read plus the write.
  - IND exit: on cpu_en with cpu_sync=1, leave IND. The opcode fetch cycle is already in exec because of the rule below.
- Sync precedence: whenever cpu_sync=1, the cycle is an opcode fetch and cpu_po must show exec, regardless of state. The state machine re-evaluates the opcode in the same cpu_en cycle. Back-to-back $B1/$91 instructions restart TRACK correctly.
- Counter: 3-bit saturating. If an interrupt or unexpected sync arrives in TRACK, return to EXEC or restart TRACK per the opcode.
- Simultaneous events:
  - A write to $0001 during an IND cycle does not change the bank of that same cycle.
  - A write to $0000 on the final IND cycle applies to the following opcode fetch.
- Readback: reg_hit = (cpu_addr[15:1]==0) & ~cpu_we, in any bank; reg_data selects exec or ind by cpu_addr[0]. Upper nibble reads 0.
- Reset mid-instruction returns immediately to EXEC with both registers at RESET_BANK.

Optional Feature:
- Macro: CBM2_BANK_RDBACK_EN.
- Defined: reg_hit and reg_data behave as above, so the register value overrides the RAM data on reads of $0000/$0001.
- Undefined: reg_hit is tied 0 and reg_data is tied 0. Reads of $0000/$0001 return RAM contents; writes and bank switching are unchanged.

Test Plan:
- Reset: release reset_n with no cycles. Expect cpu_po=$0F and exec_bank=ind_bank=$F.
- Write $01 to $0000 at cycle N. Expect cpu_po=$0F during cycle N and $01 from cycle N+1; RAM write still issued (cpu_we passes through).
- exec=$F, ind=$1; run opcode $B1 at cycle 0, no page cross. Expect cpu_po=$0F for cycles 0–3, $01 for cycle 4, $0F on the next sync.
- Same setup, opcode $91. Expect cpu_po=$01 for cycles 4 and 5 (dummy read and write), then $0F on the next sync.
- Back-to-back $B1 then $91; also assert reset_n=0 during cycle 4 of $B1. Expect each instruction tracked independently; reset forces cpu_po=$0F immediately and EXEC state.
- With CBM2_BANK_RDBACK_EN and ind=$3: read $0001 in bank 2. Expect reg_hit=1, reg_data=$03. Without the macro, expect reg_hit=0.
